rx_depacketizer: RTL and testbench

- Consumes the Ethernet MAC receive stream (ff_rx_*, 32-bit, big-endian byte lanes) inside DataController.
- Strips and validates the Ethernet header and SDR sub-header.
- Emits IQ sample words toward the deserializer/DAC path with valid/ready backpressure.
- Maintains packet, drop and sequence-gap statistics for register readback.

---
 rtl/depkt_pkg.sv | 23 ++
 rtl/skid_buffer.sv | 51 +++++
 rtl/rx_depacketizer.sv | 190 +++++++++++++++++++
 tb/tb_rx_depacketizer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/depkt_pkg.sv
// Shared definitions for the Ethernet/SDR receive depacketizer: FSM states,
// header word positions, default EtherType and the saturating counter helper.
package depkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SUBHDR,
        ST_PAYLOAD,
        ST_DROP
    } depkt_state_t;

    localparam logic [2:0]  W_DST_LO      = 3'd1;
    localparam logic [2:0]  W_TYPE        = 3'd3;
    localparam logic [2:0]  W_SUB         = 3'd4;
    localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;
    localparam logic [47:0] BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: in_ready and out_valid both come straight from flops,
// so neither handshake direction has a combinational path through this block.
module skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             skid_valid_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             in_fire;

    // Upstream may write only while the overflow slot is free.
    assign in_ready  = !skid_valid_reg;
    assign in_fire   = in_valid && !skid_valid_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else if (!out_valid_reg || out_ready) begin
            if (skid_valid_reg) begin
                out_data_reg   <= skid_data_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (in_fire) begin
                out_data_reg  <= in_data;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (in_fire) begin
            skid_data_reg  <= in_data;
            skid_valid_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/rx_depacketizer.sv
// Strips the Ethernet header and SDR sub-header from the MAC receive stream,
// forwards IQ sample words with backpressure and keeps packet statistics.
module rx_depacketizer
    import depkt_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE   = DEF_ETHERTYPE,
    parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01,
    parameter bit          CHECK_DST   = 1'b1,
    parameter int          MAX_SAMPLES = 364
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] ff_rx_data,
    input  logic        ff_rx_sop,
    input  logic        ff_rx_eop,
    input  logic [1:0]  ff_rx_mod,
    input  logic        ff_rx_err,
    input  logic        ff_rx_dval,
    output logic        ff_rx_rdy,
    output logic [31:0] smp_data,
    output logic        smp_sop,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [15:0] pkt_ok_cnt,
    output logic [15:0] pkt_drop_cnt,
    output logic [15:0] seq_gap_cnt,
    output logic [15:0] last_seq
);

    localparam int          CNT_W   = $clog2(MAX_SAMPLES + 1);
    localparam logic [15:0] MAX_CNT = 16'(MAX_SAMPLES);

    depkt_state_t state_reg, state_next;
    logic [2:0]       idx_reg, idx_next;
    logic [15:0]      dst_hi_reg, dst_hi_next;
    logic [31:0]      dst_lo_reg, dst_lo_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             first_reg, first_next;
    logic             silent_reg, silent_next;
    logic             seq_valid_reg, seq_valid_next;
    logic [15:0]      last_seq_reg, last_seq_next;
    logic [15:0]      ok_cnt_reg, drop_cnt_reg, gap_cnt_reg;
    logic             ok_inc, drop_inc, gap_inc, push;
    logic             in_fire, buf_in_ready, dst_ok;
    logic [32:0]      buf_out;

    assign ff_rx_rdy = !reset && (state_reg != ST_PAYLOAD || buf_in_ready);
    assign in_fire   = ff_rx_dval && ff_rx_rdy;
    assign dst_ok    = !CHECK_DST || ({dst_hi_reg, dst_lo_reg} == MAC_ADDR) ||
                       ({dst_hi_reg, dst_lo_reg} == BCAST_ADDR);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        dst_hi_next    = dst_hi_reg;
        dst_lo_next    = dst_lo_reg;
        cnt_next       = cnt_reg;
        first_next     = first_reg;
        silent_next    = silent_reg;
        seq_valid_next = seq_valid_reg;
        last_seq_next  = last_seq_reg;
        ok_inc         = 1'b0;
        drop_inc       = 1'b0;
        gap_inc        = 1'b0;
        push           = 1'b0;
        if (in_fire) begin
            if (ff_rx_sop) begin
                // A frame already counted ok (overlong tail) is not also a drop.
                drop_inc    = (state_reg != ST_IDLE) && !(state_reg == ST_DROP && silent_reg);
                state_next  = ST_HDR;
                idx_next    = W_DST_LO;
                dst_hi_next = ff_rx_data[15:0];
                silent_next = 1'b0;
            end else begin
                case (state_reg)
                    ST_HDR: begin
                        if (ff_rx_eop) begin
                            drop_inc   = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            idx_next = idx_reg + 3'd1;
                            if (idx_reg == W_DST_LO) dst_lo_next = ff_rx_data;
                            if (idx_reg == W_TYPE) begin
                                silent_next = 1'b0;
                                if (!dst_ok || ff_rx_data[15:0] != ETHERTYPE || !enable)
                                    state_next = ST_DROP;
                                else
                                    state_next = ST_SUBHDR;
                            end
                        end
                    end
                    ST_SUBHDR: begin
                        if (ff_rx_eop) begin
                            drop_inc   = 1'b1;
                            state_next = ST_IDLE;
                        end else if (idx_reg == W_SUB) begin
                            gap_inc        = seq_valid_reg && (ff_rx_data[31:16] != last_seq_reg + 16'd1);
                            last_seq_next  = ff_rx_data[31:16];
                            seq_valid_next = 1'b1;
                            if (ff_rx_data[15:0] == 16'd0 || ff_rx_data[15:0] > MAX_CNT) begin
                                state_next = ST_DROP;
                            end else begin
                                cnt_next   = ff_rx_data[CNT_W-1:0];
                                first_next = 1'b1;
                                state_next = ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (ff_rx_eop) begin
                            state_next = ST_IDLE;
                            if (cnt_reg == CNT_W'(1) && ff_rx_mod == 2'd0 && !ff_rx_err) begin
                                push   = 1'b1;
                                ok_inc = 1'b1;
                            end else begin
                                drop_inc = 1'b1;
                            end
                        end else begin
                            push       = 1'b1;
                            first_next = 1'b0;
                            cnt_next   = cnt_reg - CNT_W'(1);
                            if (cnt_reg == CNT_W'(1)) begin
                                ok_inc      = 1'b1;
                                silent_next = 1'b1;
                                state_next  = ST_DROP;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (ff_rx_eop) begin
                            drop_inc   = !silent_reg;
                            state_next = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            dst_hi_reg    <= '0;
            dst_lo_reg    <= '0;
            cnt_reg       <= '0;
            first_reg     <= 1'b0;
            silent_reg    <= 1'b0;
            seq_valid_reg <= 1'b0;
            last_seq_reg  <= '0;
            ok_cnt_reg    <= '0;
            drop_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            dst_hi_reg    <= dst_hi_next;
            dst_lo_reg    <= dst_lo_next;
            cnt_reg       <= cnt_next;
            first_reg     <= first_next;
            silent_reg    <= silent_next;
            seq_valid_reg <= seq_valid_next;
            last_seq_reg  <= last_seq_next;
            if (ok_inc)   ok_cnt_reg   <= sat_inc(ok_cnt_reg);
            if (drop_inc) drop_cnt_reg <= sat_inc(drop_cnt_reg);
            if (gap_inc)  gap_cnt_reg  <= sat_inc(gap_cnt_reg);
        end
    end

    skid_buffer #(.WIDTH(33)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push),
        .in_data   ({first_reg, ff_rx_data}),
        .in_ready  (buf_in_ready),
        .out_valid (smp_valid),
        .out_data  (buf_out),
        .out_ready (smp_ready)
    );

    assign smp_sop      = buf_out[32];
    assign smp_data     = buf_out[31:0];
    assign pkt_ok_cnt   = ok_cnt_reg;
    assign pkt_drop_cnt = drop_cnt_reg;
    assign seq_gap_cnt  = gap_cnt_reg;
    assign last_seq     = last_seq_reg;

endmodule

// File: tb/tb_rx_depacketizer.sv
// Testbench for rx_depacketizer: frames are driven word by word, expected samples
// are queued as they are sent and matched against the sample output stream.
module tb_rx_depacketizer;

    localparam logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] FOREIGN = 48'h02_00_00_00_00_99;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] ff_rx_data = '0;
    logic        ff_rx_sop = 1'b0;
    logic        ff_rx_eop = 1'b0;
    logic [1:0]  ff_rx_mod = 2'd0;
    logic        ff_rx_err = 1'b0;
    logic        ff_rx_dval = 1'b0;
    logic        ff_rx_rdy;
    logic [31:0] smp_data;
    logic        smp_sop;
    logic        smp_valid;
    logic        smp_ready = 1'b1;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, last_seq;

    int checks = 0;
    int passes = 0;
    int samples_seen = 0;
    int stall_cycles = 0;
    int rdy_mode = 0;
    int cyc = 0;
    logic [32:0] exp_q[$];

    rx_depacketizer dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ff_rx_data(ff_rx_data), .ff_rx_sop(ff_rx_sop), .ff_rx_eop(ff_rx_eop),
        .ff_rx_mod(ff_rx_mod), .ff_rx_err(ff_rx_err), .ff_rx_dval(ff_rx_dval),
        .ff_rx_rdy(ff_rx_rdy),
        .smp_data(smp_data), .smp_sop(smp_sop), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt),
        .seq_gap_cnt(seq_gap_cnt), .last_seq(last_seq)
    );

    always #5 clk = ~clk;

    // Downstream ready pattern: 0 = always ready, 1 = one cycle in three, 2 = never.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        smp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'b0;
    end

    // Scoreboard: every sample handshake pops and compares one expected entry.
    initial forever begin
        logic [32:0] exp;
        @(negedge clk);
        if (!reset && smp_valid && smp_ready) begin
            samples_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sample_unexpected got=%h required=none", {smp_sop, smp_data});
            end else begin
                exp = exp_q.pop_front();
                if ({smp_sop, smp_data} !== exp)
                    $display("FAIL sample got=%h required=%h", {smp_sop, smp_data}, exp);
                else begin
                    passes++;
                    $display("sample ok sop=%0d data=%h", smp_sop, smp_data);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the word transferred.
    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [1:0] mod, input logic err);
        int guard = 0;
        ff_rx_data = d; ff_rx_sop = sop; ff_rx_eop = eop;
        ff_rx_mod = mod; ff_rx_err = err; ff_rx_dval = 1'b1;
        while (!ff_rx_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
            stall_cycles++;
        end
        if (guard >= 200) begin
            checks++;
            $display("FAIL rdy_timeout got=0 required=1 data=%h", d);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype,
                              input logic [15:0] seq, input logic [15:0] count,
                              input int nsmp, input logic [1:0] mod, input logic err,
                              input bit do_eop, input int nexp, input logic [15:0] base);
        logic [31:0] w;
        bit last;
        send_word({16'h0000, dst[47:32]}, 1'b1, 1'b0, 2'd0, 1'b0);
        send_word(dst[31:0], 1'b0, 1'b0, 2'd0, 1'b0);
        send_word(32'h0A0B0C0D, 1'b0, 1'b0, 2'd0, 1'b0);
        send_word({16'h0E0F, etype}, 1'b0, 1'b0, 2'd0, 1'b0);
        send_word({seq, count}, 1'b0, do_eop && nsmp == 0, 2'd0, 1'b0);
        for (int k = 0; k < nsmp; k++) begin
            w = {base + 16'(2 * k + 1), base + 16'(2 * k + 2)};
            last = (k == nsmp - 1);
            if (k < nexp) exp_q.push_back({(k == 0) ? 1'b1 : 1'b0, w});
            send_word(w, 1'b0, do_eop && last, (do_eop && last) ? mod : 2'd0, err && last);
        end
        ff_rx_dval = 1'b0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; ff_rx_err = 1'b0; ff_rx_mod = 2'd0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || smp_valid) && g < 500) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (g >= 500) $display("FAIL drain_timeout got=%0d required=0 pending", exp_q.size());
        else passes++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_counts(input string name, input logic [15:0] ok, input logic [15:0] drop);
        checks++;
        if (pkt_ok_cnt !== ok || pkt_drop_cnt !== drop)
            $display("FAIL %s counts got ok=%0d drop=%0d required ok=%0d drop=%0d",
                     name, pkt_ok_cnt, pkt_drop_cnt, ok, drop);
        else begin
            passes++;
            $display("%s counts ok=%0d drop=%0d", name, pkt_ok_cnt, pkt_drop_cnt);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ff_rx_rdy !== 1'b0 || smp_valid !== 1'b0 || smp_sop !== 1'b0 || smp_data !== 32'd0)
            $display("FAIL reset_outputs got rdy=%b valid=%b sop=%b data=%h required 0/0/0/0",
                     ff_rx_rdy, smp_valid, smp_sop, smp_data);
        else passes++;
        checks++;
        if (pkt_ok_cnt !== 0 || pkt_drop_cnt !== 0 || seq_gap_cnt !== 0 || last_seq !== 0)
            $display("FAIL reset_counters got %h %h %h %h required all 0",
                     pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, last_seq);
        else passes++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ff_rx_rdy !== 1'b1) $display("FAIL rdy_after_reset got=%b required=1", ff_rx_rdy);
        else passes++;
        $display("test_reset done");
    endtask

    task automatic test_valid_frame();
        apply_reset();
        send_frame(MY_MAC, 16'h88B5, 16'd5, 16'd3, 3, 2'd0, 1'b0, 1, 3, 16'h0000);
        wait_drain();
        check_counts("valid_frame", 16'd1, 16'd0);
        checks++;
        if (last_seq !== 16'd5) $display("FAIL valid_last_seq got=%0d required=5", last_seq);
        else passes++;
    endtask

    task automatic test_wrong_type();
        int seen0, stall0;
        apply_reset();
        seen0 = samples_seen; stall0 = stall_cycles;
        send_frame(MY_MAC, 16'h0800, 16'd1, 16'd5, 5, 2'd0, 1'b0, 1, 0, 16'h1000);
        repeat (3) @(negedge clk);
        checks++;
        if (samples_seen != seen0 || stall_cycles != stall0)
            $display("FAIL wrong_type got samples=%0d stalls=%0d required 0/0",
                     samples_seen - seen0, stall_cycles - stall0);
        else passes++;
        check_counts("wrong_type", 16'd0, 16'd1);
    endtask

    task automatic test_filters();
        apply_reset();
        send_frame(FOREIGN, 16'h88B5, 16'd1, 16'd1, 1, 2'd0, 1'b0, 1, 0, 16'h2000);
        send_frame(BCAST, 16'h88B5, 16'd2, 16'd1, 1, 2'd0, 1'b0, 1, 1, 16'h2100);
        enable = 1'b0;
        send_frame(MY_MAC, 16'h88B5, 16'd3, 16'd1, 1, 2'd0, 1'b0, 1, 0, 16'h2200);
        enable = 1'b1;
        send_frame(MY_MAC, 16'h88B5, 16'd4, 16'd0, 1, 2'd0, 1'b0, 1, 0, 16'h2300);
        send_frame(MY_MAC, 16'h88B5, 16'd5, 16'd365, 2, 2'd0, 1'b0, 1, 0, 16'h2400);
        send_frame(MY_MAC, 16'h88B5, 16'd6, 16'd2, 4, 2'd0, 1'b0, 1, 2, 16'h2500);
        wait_drain();
        check_counts("filters", 16'd2, 16'd4);
    endtask

    task automatic test_seq_gap();
        apply_reset();
        send_frame(MY_MAC, 16'h88B5, 16'd7, 16'd1, 1, 2'd0, 1'b0, 1, 1, 16'h3000);
        send_frame(MY_MAC, 16'h88B5, 16'd9, 16'd1, 1, 2'd0, 1'b0, 1, 1, 16'h3100);
        wait_drain();
        checks++;
        if (seq_gap_cnt !== 16'd1 || last_seq !== 16'd9)
            $display("FAIL seq_gap got gap=%0d last=%0d required gap=1 last=9", seq_gap_cnt, last_seq);
        else passes++;
        send_frame(MY_MAC, 16'h88B5, 16'd10, 16'd1, 1, 2'd0, 1'b0, 1, 1, 16'h3200);
        wait_drain();
        checks++;
        if (seq_gap_cnt !== 16'd1 || last_seq !== 16'd10)
            $display("FAIL seq_contig got gap=%0d last=%0d required gap=1 last=10", seq_gap_cnt, last_seq);
        else passes++;
        check_counts("seq_gap", 16'd3, 16'd0);
    endtask

    task automatic test_short_and_err();
        apply_reset();
        send_frame(MY_MAC, 16'h88B5, 16'd1, 16'd4, 3, 2'd0, 1'b0, 1, 2, 16'h4000);
        wait_drain();
        check_counts("short_eop", 16'd0, 16'd1);
        send_frame(MY_MAC, 16'h88B5, 16'd2, 16'd2, 2, 2'd0, 1'b1, 1, 1, 16'h4100);
        wait_drain();
        check_counts("err_eop", 16'd0, 16'd2);
        send_frame(MY_MAC, 16'h88B5, 16'd3, 16'd1, 1, 2'd2, 1'b0, 1, 0, 16'h4200);
        wait_drain();
        check_counts("mod_eop", 16'd0, 16'd3);
    endtask

    task automatic test_backpressure();
        int seen0, stall0;
        apply_reset();
        rdy_mode = 1;
        seen0 = samples_seen; stall0 = stall_cycles;
        send_frame(MY_MAC, 16'h88B5, 16'd1, 16'd8, 8, 2'd0, 1'b0, 1, 8, 16'h5000);
        wait_drain();
        rdy_mode = 0;
        checks++;
        if (samples_seen - seen0 != 8 || stall_cycles == stall0)
            $display("FAIL backpressure got samples=%0d stalls=%0d required samples=8 stalls>0",
                     samples_seen - seen0, stall_cycles - stall0);
        else passes++;
        check_counts("backpressure", 16'd1, 16'd0);
    endtask

    task automatic test_back_to_back();
        int seen0;
        apply_reset();
        send_frame(MY_MAC, 16'h88B5, 16'd20, 16'd4, 2, 2'd0, 1'b0, 0, 2, 16'h6000);
        send_frame(MY_MAC, 16'h88B5, 16'd21, 16'd2, 2, 2'd0, 1'b0, 1, 2, 16'h6100);
        wait_drain();
        check_counts("sop_mid_payload", 16'd1, 16'd1);
        checks++;
        if (seq_gap_cnt !== 16'd0) $display("FAIL b2b_gap got=%0d required=0", seq_gap_cnt);
        else passes++;
        // Stall the output, leave samples buffered mid-packet, then reset.
        rdy_mode = 2;
        send_frame(MY_MAC, 16'h88B5, 16'd22, 16'd8, 2, 2'd0, 1'b0, 0, 0, 16'h6200);
        checks++;
        if (smp_valid !== 1'b1) $display("FAIL prereset_valid got=%b required=1", smp_valid);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (smp_valid !== 1'b0 || pkt_ok_cnt !== 0 || pkt_drop_cnt !== 0 || seq_gap_cnt !== 0 || last_seq !== 0)
            $display("FAIL midreset got valid=%b ok=%0d drop=%0d gap=%0d last=%0d required all 0",
                     smp_valid, pkt_ok_cnt, pkt_drop_cnt, seq_gap_cnt, last_seq);
        else passes++;
        reset = 1'b0;
        rdy_mode = 0;
        seen0 = samples_seen;
        for (int k = 0; k < 4; k++)
            send_word(32'h7000_0000 + 32'(k), 1'b0, k == 3, 2'd0, 1'b0);
        ff_rx_dval = 1'b0; ff_rx_eop = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (samples_seen != seen0 || smp_valid !== 1'b0)
            $display("FAIL postreset_tail got samples=%0d valid=%b required 0/0",
                     samples_seen - seen0, smp_valid);
        else passes++;
        check_counts("postreset_tail", 16'd0, 16'd0);
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_wrong_type();
        test_filters();
        test_seq_gap();
        test_short_and_err();
        test_backpressure();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
